// File: rtl/vital_sign_monitor.sv
// Per-channel threshold monitor with persistence filtering, latched alerts,
// acknowledge-assisted recovery and a silent-sensor watchdog.

module vsm_channel #(
  parameter int DATA_W    = 8,
  parameter int PERSIST   = 3,
  parameter int CLEAR_CNT = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] data,
  input  logic              valid,
  input  logic [DATA_W-1:0] lo,
  input  logic [DATA_W-1:0] hi,
  input  logic              ack,
  output logic              alert,
  output logic              stale,
  output logic              alert_nxt,
  output logic [DATA_W-1:0] cap_nxt
);
  localparam int CMAX = (PERSIST > CLEAR_CNT) ? PERSIST : CLEAR_CNT;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int TW   = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] P_LAST = CW'(PERSIST - 1);
  localparam logic [CW-1:0] C_LAST = CW'(CLEAR_CNT - 1);
  localparam logic [CW-1:0] ONE    = CW'(1);
  localparam logic [TW-1:0] T_MAX  = TW'(TIMEOUT);

  typedef enum logic [1:0] {NORMAL, PENDING, ALERT, RECOVER} state_e;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] cap_q, cap_d;
  logic [TW-1:0]     wd_q, wd_d;
  logic              alert_q, alert_d;
  logic              stale_q, stale_d;
  logic              abn;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    abn     = (data < lo) || (data > hi);
    if (valid) begin
      unique case (state_q)
        NORMAL:
          if (abn) begin
            if (PERSIST == 1) begin
              state_d = ALERT; cap_d = data; cnt_d = '0;
            end else begin
              state_d = PENDING; cnt_d = ONE;
            end
          end
        PENDING:
          if (!abn) begin
            state_d = NORMAL; cnt_d = '0;
          end else if (cnt_q == P_LAST) begin
            state_d = ALERT; cap_d = data; cnt_d = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        ALERT:
          if (!abn) begin
            if (CLEAR_CNT == 1) begin
              state_d = NORMAL; cnt_d = '0;
            end else begin
              state_d = RECOVER; cnt_d = ONE;
            end
          end
        RECOVER:
          if (abn) begin
            state_d = ALERT; cap_d = data; cnt_d = '0;
          end else if (cnt_q == C_LAST) begin
            state_d = NORMAL; cnt_d = '0;
          end else begin
            cnt_d = cnt_q + ONE;
          end
        default: state_d = NORMAL;
      endcase
    end else if (ack && state_q == RECOVER) begin
      // ack only short-circuits an alert that is already on its way out
      state_d = NORMAL; cnt_d = '0;
    end
    wd_d      = valid ? '0 : ((wd_q == T_MAX) ? wd_q : wd_q + TW'(1));
    stale_d   = (wd_d == T_MAX);
    alert_d   = (state_d == ALERT) || (state_d == RECOVER);
    alert_nxt = alert_d;
    cap_nxt   = cap_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NORMAL;
      cnt_q   <= '0;
      cap_q   <= '0;
      wd_q    <= '0;
      alert_q <= 1'b0;
      stale_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cap_q   <= cap_d;
      wd_q    <= wd_d;
      alert_q <= alert_d;
      stale_q <= stale_d;
    end
  end

  assign alert = alert_q;
  assign stale = stale_q;
endmodule

module vital_sign_monitor #(
  parameter int N_CH      = 3,
  parameter int DATA_W    = 8,
  parameter int PERSIST   = 3,
  parameter int CLEAR_CNT = 2,
  parameter int TIMEOUT   = 255,
  parameter int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH*DATA_W-1:0]   sample_data,
  input  logic [N_CH-1:0]          sample_valid,
  input  logic [N_CH*DATA_W-1:0]   thresh_lo,
  input  logic [N_CH*DATA_W-1:0]   thresh_hi,
  input  logic [N_CH-1:0]          alert_ack,
  output logic [N_CH-1:0]          alert,
  output logic [N_CH-1:0]          stale,
  output logic                     any_alert,
  output logic [CH_W-1:0]          alert_ch,
  output logic [DATA_W-1:0]        alert_data
);
  logic [N_CH-1:0]             alert_nxt;
  logic [N_CH-1:0][DATA_W-1:0] cap_nxt;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    vsm_channel #(
      .DATA_W(DATA_W), .PERSIST(PERSIST), .CLEAR_CNT(CLEAR_CNT), .TIMEOUT(TIMEOUT)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .data      (sample_data[g*DATA_W +: DATA_W]),
      .valid     (sample_valid[g]),
      .lo        (thresh_lo[g*DATA_W +: DATA_W]),
      .hi        (thresh_hi[g*DATA_W +: DATA_W]),
      .ack       (alert_ack[g]),
      .alert     (alert[g]),
      .stale     (stale[g]),
      .alert_nxt (alert_nxt[g]),
      .cap_nxt   (cap_nxt[g])
    );
  end

  logic              any_alert_q, any_alert_d;
  logic [CH_W-1:0]   alert_ch_q, alert_ch_d;
  logic [DATA_W-1:0] alert_data_q, alert_data_d;

  // Encode from next-state values so the summary lands on the same edge as alert.
  always_comb begin
    any_alert_d  = |alert_nxt;
    alert_ch_d   = '0;
    alert_data_d = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (alert_nxt[i]) begin
        alert_ch_d   = CH_W'(i);
        alert_data_d = cap_nxt[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      any_alert_q  <= 1'b0;
      alert_ch_q   <= '0;
      alert_data_q <= '0;
    end else begin
      any_alert_q  <= any_alert_d;
      alert_ch_q   <= alert_ch_d;
      alert_data_q <= alert_data_d;
    end
  end

  assign any_alert  = any_alert_q;
  assign alert_ch   = alert_ch_q;
  assign alert_data = alert_data_q;
endmodule

// File: tb/tb_vital_sign_monitor.sv
// Directed scenarios plus randomized traffic against a run-length reference model.

module tb_vital_sign_monitor;
  localparam int N_CH = 3, DW = 8, PERSIST = 3, CLEAR_CNT = 2, TIMEOUT = 20;

  logic              clk = 1'b0;
  logic              reset;
  logic [N_CH*DW-1:0] sample_data, thresh_lo, thresh_hi;
  logic [N_CH-1:0]   sample_valid, alert_ack, alert, stale;
  logic              any_alert;
  logic [1:0]        alert_ch;
  logic [DW-1:0]     alert_data;

  int n_checks = 0;
  int n_err    = 0;

  // reference model: run lengths of abnormal/normal samples and silence
  int abn_run[N_CH], nrm_run[N_CH], silent[N_CH], cap[N_CH];
  bit alerted[N_CH];

  vital_sign_monitor #(
    .N_CH(N_CH), .DATA_W(DW), .PERSIST(PERSIST), .CLEAR_CNT(CLEAR_CNT), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .sample_data(sample_data), .sample_valid(sample_valid),
    .thresh_lo(thresh_lo), .thresh_hi(thresh_hi), .alert_ack(alert_ack),
    .alert(alert), .stale(stale), .any_alert(any_alert), .alert_ch(alert_ch),
    .alert_data(alert_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_update();
    for (int c = 0; c < N_CH; c++) begin
      int d, lo, hi;
      bit abn;
      if (reset) begin
        abn_run[c] = 0; nrm_run[c] = 0; silent[c] = 0; cap[c] = 0; alerted[c] = 0;
        continue;
      end
      d  = int'(sample_data[c*DW +: DW]);
      lo = int'(thresh_lo[c*DW +: DW]);
      hi = int'(thresh_hi[c*DW +: DW]);
      abn = (d < lo) || (d > hi);
      if (sample_valid[c]) silent[c] = 0;
      else if (silent[c] < TIMEOUT) silent[c]++;
      if (sample_valid[c]) begin
        if (!alerted[c]) begin
          if (abn) begin
            abn_run[c]++;
            if (abn_run[c] >= PERSIST) begin
              alerted[c] = 1; cap[c] = d; nrm_run[c] = 0;
            end
          end else abn_run[c] = 0;
        end else if (!abn) begin
          nrm_run[c]++;
          if (nrm_run[c] >= CLEAR_CNT) begin
            alerted[c] = 0; abn_run[c] = 0; nrm_run[c] = 0;
          end
        end else if (nrm_run[c] > 0) begin
          cap[c] = d; nrm_run[c] = 0;
        end
      end else if (alert_ack[c] && alerted[c] && nrm_run[c] > 0) begin
        alerted[c] = 0; abn_run[c] = 0; nrm_run[c] = 0;
      end
    end
  endtask

  task automatic check_model();
    logic [N_CH-1:0] ea, es;
    int ech, edata;
    ech = 0; edata = 0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      ea[c] = alerted[c];
      es[c] = (silent[c] == TIMEOUT);
      if (alerted[c]) begin ech = c; edata = cap[c]; end
    end
    chk("m_alert", alert, ea);
    chk("m_stale", stale, es);
    chk("m_any", any_alert, |ea);
    chk("m_ch", alert_ch, ech);
    chk("m_data", alert_data, edata);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_model();
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); reset = 1'b0;
  endtask

  task automatic send(input int ch, input int v);
    sample_valid = '0;
    sample_valid[ch] = 1'b1;
    sample_data[ch*DW +: DW] = DW'(v);
    step();
    sample_valid = '0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic set_thr(input int ch, input int lo, input int hi);
    thresh_lo[ch*DW +: DW] = DW'(lo);
    thresh_hi[ch*DW +: DW] = DW'(hi);
  endtask

  function automatic int pick(input int lo, input int hi);
    int v;
    case ($urandom_range(0, 3))
      0: v = lo + $urandom_range(0, 2) - 1;
      1: v = hi + $urandom_range(0, 2) - 1;
      2: v = $urandom_range(0, 255);
      default: v = (lo + hi) / 2;
    endcase
    if (v < 0) v = 0;
    if (v > 255) v = 255;
    return v;
  endfunction

  initial begin
    reset = 1'b1; sample_data = '0; sample_valid = '0; alert_ack = '0;
    set_thr(0, 60, 120); set_thr(1, 85, 100); set_thr(2, 1, 255);

    // reset state and stale watchdog timing
    do_reset();
    chk("rst_alert", alert, 0); chk("rst_stale", stale, 0);
    chk("rst_any", any_alert, 0); chk("rst_ch", alert_ch, 0); chk("rst_data", alert_data, 0);
    idle(19);
    chk("stale_19", stale[2], 0);
    idle(1);
    chk("stale_20", stale[2], 1);
    send(2, 0);
    chk("stale_clr", stale[2], 0);
    chk("ch2_pend", alert[2], 0);
    send(2, 0); send(2, 0);
    chk("ch2_alert", alert[2], 1); chk("ch2_idx", alert_ch, 2); chk("ch2_data", alert_data, 0);

    // raise, then recovery variants
    do_reset();
    send(0, 80); send(0, 130); send(0, 130);
    chk("r21_pre", alert[0], 0);
    send(0, 130);
    chk("r21_alert", alert[0], 1); chk("r21_any", any_alert, 1);
    chk("r21_ch", alert_ch, 0); chk("r21_data", alert_data, 130);
    send(0, 80);
    chk("rec_mid", alert[0], 1);
    send(0, 80);
    chk("rec_done", alert[0], 0);
    send(0, 130); send(0, 130); send(0, 130);
    send(0, 80); send(0, 125);
    chk("rec_back", alert[0], 1); chk("rec_recap", alert_data, 125);
    alert_ack = 3'b001; step(); alert_ack = '0;
    chk("ack_in_alert", alert[0], 1);
    send(0, 80);
    alert_ack = 3'b001; sample_valid = 3'b001; sample_data[7:0] = 8'd200; step();
    sample_valid = '0; alert_ack = '0;
    chk("ack_with_valid", alert[0], 1); chk("ack_v_data", alert_data, 200);
    send(0, 80);
    alert_ack = 3'b001; step(); alert_ack = '0;
    chk("ack_recover", alert[0], 0);

    // persistence break and inclusive bounds
    do_reset();
    send(0, 130); send(0, 130); send(0, 80); send(0, 130);
    chk("r22_break", alert[0], 0);
    send(1, 85); send(1, 100); send(1, 85);
    chk("r22_bound", alert[1], 0);

    // priority among channels
    do_reset();
    send(1, 110); send(1, 110); send(1, 110);
    chk("r24_ch1", alert_ch, 1); chk("r24_d1", alert_data, 110);
    send(0, 50); send(0, 50); send(0, 50);
    chk("r24_ch0", alert_ch, 0); chk("r24_d0", alert_data, 50);
    send(0, 80); send(0, 80);
    chk("r24_back", alert_ch, 1); chk("r24_dback", alert_data, 110);

    // reset discards history, including a same-cycle valid
    do_reset();
    send(0, 130); send(0, 130);
    send(1, 110); send(1, 110); send(1, 110);
    reset = 1'b1; sample_valid = 3'b001; sample_data[7:0] = 8'd130; step();
    reset = 1'b0; sample_valid = '0;
    chk("r26_alert", alert, 0); chk("r26_any", any_alert, 0);
    chk("r26_ch", alert_ch, 0); chk("r26_data", alert_data, 0);
    send(0, 130); send(0, 130);
    chk("r26_two", alert[0], 0);
    send(0, 130);
    chk("r26_three", alert[0], 1);

    // randomized traffic, thresholds reshuffled per segment
    for (int seg = 0; seg < 6; seg++) begin
      int quiet;
      quiet = $urandom_range(0, N_CH);
      for (int c = 0; c < N_CH; c++) begin
        int a, b;
        a = $urandom_range(0, 255); b = $urandom_range(0, 255);
        if (a > b) set_thr(c, b, a); else set_thr(c, a, b);
      end
      for (int k = 0; k < 150; k++) begin
        reset = ($urandom_range(0, 99) < 2);
        for (int c = 0; c < N_CH; c++) begin
          int lo, hi;
          lo = int'(thresh_lo[c*DW +: DW]); hi = int'(thresh_hi[c*DW +: DW]);
          sample_valid[c] = (c == quiet) ? ($urandom_range(0, 31) == 0) : ($urandom_range(0, 1) == 1);
          sample_data[c*DW +: DW] = DW'(pick(lo, hi));
          alert_ack[c] = ($urandom_range(0, 3) == 0);
        end
        step();
      end
      reset = 1'b0; sample_valid = '0; alert_ack = '0;
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
